conv_input_loader: RTL and testbench
====================================

# conv_input_loader

Upstream feeder for the convolution coprocessor. Accepts a size configuration and a valid/ready sample stream, writes the input signal into the X memory and the kernel into the H memory, then pulses the coprocessor `start`. It waits for the coprocessor's `done` before accepting the next job. It owns the write ports of both operand memories and the size registers the coprocessor compares against.

## Interface
- `DATA_W`, default 8: sample width.
- `ADDR_W`, default 5: memory address width; the size fields are `ADDR_W+1` bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: job configuration valid.
- `cfg_size_x` in ADDR_W+1: number of X samples, legal range 1..2^ADDR_W.
- `cfg_size_h` in ADDR_W+1: number of H taps, legal range 1..2^ADDR_W.
- `cfg_ready` out 1: configuration accepted when `cfg_valid && cfg_ready`.
- `in_valid` in 1: stream sample valid.
- `in_data` in DATA_W: stream sample.
- `in_last` in 1: marks the final H tap of the job.
- `in_ready` out 1: stream sample accepted when `in_valid && in_ready`.
- `memx_we` out 1: X memory write enable.
- `memx_addr` out ADDR_W: X memory write address.
- `memx_wdata` out DATA_W: X memory write data.
- `memh_we` out 1: H memory write enable.
- `memh_addr` out ADDR_W: H memory write address.
- `memh_wdata` out DATA_W: H memory write data.
- `size_x` out ADDR_W+1: latched X length, forwarded to the coprocessor.
- `size_h` out ADDR_W+1: latched H length, forwarded to the coprocessor.
- `cop_start` out 1: one-cycle start pulse to the coprocessor.
- `cop_done` in 1: coprocessor done pulse.
- `busy` out 1: high in every state except IDLE.
- `job_done` out 1: one-cycle pulse when a job completes.
- `load_err` out 1: one-cycle pulse when a job is aborted or a configuration is rejected.

## Operation
- States: IDLE, LOAD_X, LOAD_H, START, WAIT.
- IDLE: `cfg_ready`=1, `in_ready`=0.
  - On a cfg handshake with both sizes in the legal range: latch `size_x`/`size_h`, clear the address counter, go to LOAD_X.
  - On a cfg handshake with either size equal to 0 or greater than 2^ADDR_W: pulse `load_err`, stay in IDLE, leave `size_x`/`size_h` unchanged.
- LOAD_X: `in_ready`=1. Each accepted beat writes X[cnt] and increments cnt.
  - When the beat with cnt = size_x-1 is accepted: clear cnt, go to LOAD_H.
- LOAD_H: `in_ready`=1. Each accepted beat writes H[cnt] and increments cnt.
  - Beat with cnt = size_h-1 and `in_last`=1: go to START.
- Framing errors abort the job: pulse `load_err` and go to IDLE with no `cop_start`. The abort cases are:
  - `in_last`=1 on any X beat;
  - `in_last`=1 on an H beat before cnt = size_h-1;
  - `in_last`=0 on the H beat with cnt = size_h-1.
  - The offending beat is still written to memory.
- START: `in_ready`=0. Assert `cop_start` for exactly one cycle, then go to WAIT.
- WAIT: `in_ready`=0, `cfg_ready`=0. On `cop_done`=1: pulse `job_done`, go to IDLE. The block waits indefinitely; there is no timeout.
- `cop_done` is ignored in every state except WAIT.
- `cfg_valid` is ignored outside IDLE.
- cnt width is ADDR_W+1 and never wraps inside a legal job. The address outputs carry cnt[ADDR_W-1:0].
- Reset, whether idle or mid-job:
  - next state IDLE; cnt=0; `size_x`=`size_h`=0;
  - all `*_we`, `cop_start`, `job_done` and `load_err` = 0;
  - `busy`=0; `cfg_ready`=1 after the reset edge.
  - A job interrupted by reset is never started.

## Timing
- `cfg_ready` and `in_ready` are combinational from the state only. They never depend on `in_valid` or `cfg_valid`.
- Memory write port outputs (`*_we`/`*_addr`/`*_wdata`) are registered. A beat accepted at edge t drives its write during cycle t..t+1, and the memory captures it at edge t+1.
- `cop_start`, `job_done`, `load_err` and `busy` are registered outputs.
- Last H beat accepted at edge t:
  - state = START after edge t;
  - `cop_start` = 1 during cycle t+1..t+2, which is after the final H write has landed.
- `cop_done` sampled high at edge d in WAIT: `job_done` = 1 for cycle d..d+1, and `cfg_ready` = 1 from edge d.
- Throughput: one sample per cycle while `in_valid` is held high. Gaps in `in_valid` insert idle cycles and cause no error.
- Minimum job length: 1 (cfg) + size_x + size_h + 1 (start) + coprocessor latency cycles.

## Test plan
- Config 4/3, stream X=1,2,3,4 then H=5,6,7 with `in_last` on 7, no gaps:
  - X[0..3] = 1..4 and H[0..2] = 5..7;
  - `cop_start` is a single pulse 1 cycle after the last write;
  - `cop_done` after 10 cycles gives a `job_done` pulse, and `busy` drops the same cycle.
- Same job with `in_valid` toggled every other cycle: identical memory contents, and `cop_start` arrives 7 cycles later than in the gapless case.
- `in_last`=1 on the 2nd H beat of a 4/3 job: `load_err` pulses, no `cop_start`, state returns to IDLE, and the next legal job completes normally.
- Config `size_x`=0 and config `size_h`=33 (ADDR_W=5): each gives a `load_err` pulse, `busy` stays 0, and `size_x`/`size_h` keep their previous values.
- `rst` asserted mid-LOAD_H:
  - all outputs are at reset values after the edge;
  - no `cop_start`;
  - a `cop_done` pulse arriving later is ignored, and no `job_done` occurs.
- Maximum job 32/32 with `cfg_valid` held high during WAIT:
  - addresses 0..31 are written, with no wrap to 0;
  - the second config is accepted only on the first cycle after `job_done`.

Source files
------------

// File: rtl/conv_input_loader.sv
// conv_input_loader: loads X and H operand memories from a sample stream, then starts the coprocessor
module conv_input_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [ADDR_W:0]   cfg_size_x,
    input  logic [ADDR_W:0]   cfg_size_h,
    output logic              cfg_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              memx_we,
    output logic [ADDR_W-1:0] memx_addr,
    output logic [DATA_W-1:0] memx_wdata,
    output logic              memh_we,
    output logic [ADDR_W-1:0] memh_addr,
    output logic [DATA_W-1:0] memh_wdata,
    output logic [ADDR_W:0]   size_x,
    output logic [ADDR_W:0]   size_h,
    output logic              cop_start,
    input  logic              cop_done,
    output logic              busy,
    output logic              job_done,
    output logic              load_err
);
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_H, START, WAIT} state_t;

    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] MAX_SIZE = ONE << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     size_x_q, size_x_d, size_h_q, size_h_d;
    logic                x_we_q, x_we_d, h_we_q, h_we_d;
    logic [ADDR_W-1:0]   x_addr_q, x_addr_d, h_addr_q, h_addr_d;
    logic [DATA_W-1:0]   x_wdata_q, x_wdata_d, h_wdata_q, h_wdata_d;
    logic                start_q, start_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic                cfg_ok, x_end, h_end;

    assign cfg_ok = (cfg_size_x != '0) && (cfg_size_x <= MAX_SIZE) &&
                    (cfg_size_h != '0) && (cfg_size_h <= MAX_SIZE);
    assign x_end  = (cnt_q + ONE) == size_x_q;
    assign h_end  = (cnt_q + ONE) == size_h_q;

    assign cfg_ready  = state_q == IDLE;
    assign in_ready   = (state_q == LOAD_X) || (state_q == LOAD_H);
    assign memx_we    = x_we_q;
    assign memx_addr  = x_addr_q;
    assign memx_wdata = x_wdata_q;
    assign memh_we    = h_we_q;
    assign memh_addr  = h_addr_q;
    assign memh_wdata = h_wdata_q;
    assign size_x     = size_x_q;
    assign size_h     = size_h_q;
    assign cop_start  = start_q;
    assign job_done   = done_q;
    assign load_err   = err_q;
    assign busy       = busy_q;

    // Next state, counter, size latch and registered-output next values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_x_d  = size_x_q;
        size_h_d  = size_h_q;
        x_we_d    = 1'b0;
        h_we_d    = 1'b0;
        x_addr_d  = cnt_q[ADDR_W-1:0];
        h_addr_d  = cnt_q[ADDR_W-1:0];
        x_wdata_d = in_data;
        h_wdata_d = in_data;
        start_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (cfg_valid) begin
                if (cfg_ok) begin
                    size_x_d = cfg_size_x;
                    size_h_d = cfg_size_h;
                    cnt_d    = '0;
                    state_d  = LOAD_X;
                end else err_d = 1'b1;
            end
            LOAD_X: if (in_valid) begin
                x_we_d = 1'b1;
                if (in_last) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (x_end) begin
                    cnt_d   = '0;
                    state_d = LOAD_H;
                end else cnt_d = cnt_q + ONE;
            end
            LOAD_H: if (in_valid) begin
                h_we_d = 1'b1;
                if (in_last != h_end) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (h_end) state_d = START;
                else cnt_d = cnt_q + ONE;
            end
            START: begin
                start_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (cop_done) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            size_x_q  <= '0;
            size_h_q  <= '0;
            x_we_q    <= 1'b0;
            h_we_q    <= 1'b0;
            x_addr_q  <= '0;
            h_addr_q  <= '0;
            x_wdata_q <= '0;
            h_wdata_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_x_q  <= size_x_d;
            size_h_q  <= size_h_d;
            x_we_q    <= x_we_d;
            h_we_q    <= h_we_d;
            x_addr_q  <= x_addr_d;
            h_addr_q  <= h_addr_d;
            x_wdata_q <= x_wdata_d;
            h_wdata_q <= h_wdata_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_conv_input_loader.sv
// tb_conv_input_loader: directed self-checking bench for conv_input_loader
module tb_conv_input_loader;
    localparam int DW = 8;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready;
    logic [AW:0] cfg_size_x = '0, cfg_size_h = '0;
    logic in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic memx_we, memh_we;
    logic [AW-1:0] memx_addr, memh_addr;
    logic [DW-1:0] memx_wdata, memh_wdata;
    logic [AW:0] size_x, size_h;
    logic cop_start, job_done, load_err, busy;
    logic cop_done = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] xm [32];
    logic [DW-1:0] hm [32];
    logic clr = 1'b1;
    int cyc = 0, n_start = 0, n_done = 0, nx_wr = 0, start_cyc = 0, cfg_cyc = 0, last_wr_cyc = 0;

    always #5 clk = ~clk;

    conv_input_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_size_x(cfg_size_x), .cfg_size_h(cfg_size_h), .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .memx_we(memx_we), .memx_addr(memx_addr), .memx_wdata(memx_wdata),
        .memh_we(memh_we), .memh_addr(memh_addr), .memh_wdata(memh_wdata),
        .size_x(size_x), .size_h(size_h),
        .cop_start(cop_start), .cop_done(cop_done),
        .busy(busy), .job_done(job_done), .load_err(load_err)
    );

    // Operand memory model plus event counters with edge timestamps
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                xm[i] <= 8'hff;
                hm[i] <= 8'hff;
            end
            nx_wr <= 0;
        end else begin
            if (memx_we) begin
                xm[memx_addr] <= memx_wdata;
                nx_wr <= nx_wr + 1;
            end
            if (memh_we) begin
                hm[memh_addr] <= memh_wdata;
                last_wr_cyc <= cyc;
            end
        end
        if (cop_start) begin
            n_start <= n_start + 1;
            start_cyc <= cyc;
        end
        if (job_done) n_done <= n_done + 1;
        if (cfg_valid && cfg_ready) cfg_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int sx, input int sh);
        cfg_valid = 1'b1;
        cfg_size_x = (AW+1)'(sx);
        cfg_size_h = (AW+1)'(sh);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic beat(input int d, input logic l, input logic gap);
        if (gap) tick();
        in_valid = 1'b1;
        in_data = DW'(d);
        in_last = l;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 60 && !cop_start; i++) tick();
        chk("start_seen", cop_start, 1);
        tick();
        chk("start_single", cop_start, 0);
        chk("busy_wait", busy, 1);
    endtask

    task automatic run_job(input logic gap);
        cfg(4, 3);
        for (int i = 0; i < 4; i++) beat(i + 1, 1'b0, gap);
        for (int i = 0; i < 3; i++) beat(5 + i, i == 2, gap);
        wait_start();
    endtask

    task automatic finish_job();
        int s0 = n_start;
        int d0 = n_done;
        repeat (10) tick();
        chk("no_done_early", n_done - d0, 0);
        chk("no_restart", n_start - s0, 0);
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        chk("job_done", job_done, 1);
        chk("busy_drop", busy, 0);
        chk("cfg_ready_done", cfg_ready, 1);
        tick();
        chk("job_done_pulse", job_done, 0);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 4; i++) chk("xmem", 32'(xm[i]), i + 1);
        for (int i = 0; i < 3; i++) chk("hmem", 32'(hm[i]), i + 5);
    endtask

    initial begin
        int s0, d0;
        repeat (2) tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_size_x", size_x, 0);
        chk("rst_size_h", size_h, 0);
        chk("rst_start", cop_start, 0);
        rst = 1'b0;
        clr = 1'b0;
        tick();

        // Gapless 4/3 job
        cfg(4, 3);
        chk("cfg_busy", busy, 1);
        chk("cfg_size_x", size_x, 4);
        chk("cfg_size_h", size_h, 3);
        chk("ld_in_ready", in_ready, 1);
        chk("ld_cfg_ready", cfg_ready, 0);
        for (int i = 0; i < 4; i++) beat(i + 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) beat(5 + i, i == 2, 1'b0);
        wait_start();
        chk("lat_gapless", start_cyc - cfg_cyc, 9);
        chk("start_after_wr", start_cyc - last_wr_cyc, 1);
        finish_job();
        check_mem();

        // Same job with idle cycles between beats
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run_job(1'b1);
        chk("lat_gapped", start_cyc - cfg_cyc, 16);
        finish_job();
        check_mem();

        // Early in_last on the second H beat aborts the job
        s0 = n_start;
        cfg(4, 3);
        for (int i = 0; i < 4; i++) beat(i + 1, 1'b0, 1'b0);
        beat(15, 1'b0, 1'b0);
        beat(16, 1'b1, 1'b0);
        chk("abort_err", load_err, 1);
        chk("abort_busy", busy, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        tick();
        chk("abort_err_pulse", load_err, 0);
        repeat (3) tick();
        chk("abort_no_start", n_start - s0, 0);
        chk("abort_written", 32'(hm[1]), 16);
        run_job(1'b0);
        finish_job();

        // Illegal configurations are rejected without touching sizes
        cfg(0, 3);
        chk("bad0_err", load_err, 1);
        chk("bad0_busy", busy, 0);
        chk("bad0_size_x", size_x, 4);
        cfg(4, 33);
        chk("bad33_err", load_err, 1);
        chk("bad33_busy", busy, 0);
        chk("bad33_size_h", size_h, 3);
        tick();
        chk("bad_err_pulse", load_err, 0);

        // Reset in the middle of LOAD_H
        s0 = n_start;
        d0 = n_done;
        cfg(4, 3);
        for (int i = 0; i < 4; i++) beat(i + 1, 1'b0, 1'b0);
        beat(5, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_size_x", size_x, 0);
        chk("mid_rst_size_h", size_h, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_memh_we", memh_we, 0);
        repeat (3) tick();
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_start", n_start - s0, 0);
        chk("mid_rst_no_done", n_done - d0, 0);
        chk("mid_rst_busy_after", busy, 0);

        // Maximum 32/32 job with the next config held during WAIT
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cfg(32, 32);
        chk("max_size_x", size_x, 32);
        for (int i = 0; i < 32; i++) beat(i + 1, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) beat(100 + i, i == 31, 1'b0);
        wait_start();
        chk("max_x_writes", nx_wr, 32);
        chk("max_x0", 32'(xm[0]), 1);
        chk("max_x31", 32'(xm[31]), 32);
        chk("max_h0", 32'(hm[0]), 100);
        chk("max_h31", 32'(hm[31]), 131);
        cfg_valid = 1'b1;
        cfg_size_x = 2;
        cfg_size_h = 2;
        repeat (3) tick();
        chk("hold_busy", busy, 1);
        chk("hold_size_x", size_x, 32);
        cop_done = 1'b1;
        tick();
        cop_done = 1'b0;
        chk("hold_job_done", job_done, 1);
        chk("hold_not_yet", size_x, 32);
        chk("hold_cfg_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("hold_accept_x", size_x, 2);
        chk("hold_accept_h", size_h, 2);
        chk("hold_busy2", busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
